// File: rtl/uart_prog_loader_if.sv
// ---------------------------------------------------------------------------
// uart_prog_loader_if
//
// Purpose : write-side bus of the UART program loader. The loader drives a
//           word address, an assembled 32-bit word, a one-cycle write strobe
//           and a sticky "download complete" flag toward the program memory.
//
// Signals :
//   upg_adr_o   [14:0]  word address; bit 14 selects the memory downstream
//   upg_dat_o   [31:0]  assembled little-endian word
//   upg_wen_o           one-cycle write strobe for upg_adr_o/upg_dat_o
//   upg_done_o          download complete (sticky until reset or hold)
//
// Modports: master = loader side (drives everything), slave = memory side.
// ---------------------------------------------------------------------------
interface uart_prog_loader_if;
   logic [14:0] upg_adr_o;
   logic [31:0] upg_dat_o;
   logic        upg_wen_o;
   logic        upg_done_o;

   modport master (
      output upg_adr_o,
      output upg_dat_o,
      output upg_wen_o,
      output upg_done_o
   );

   modport slave (
      input upg_adr_o,
      input upg_dat_o,
      input upg_wen_o,
      input upg_done_o
   );
endinterface

// File: rtl/uart_prog_loader.sv
// ---------------------------------------------------------------------------
// uart_prog_loader
//
// Purpose : receives an 8N1 UART byte stream (LSB first), packs every four
//           accepted bytes little-endian into a 32-bit word and writes it to
//           consecutive word addresses starting at 0. The download ends when
//           the line stays idle for TIMEOUT_CLKS cycles after at least one
//           byte, or after the word at address 0x7FFF has been written.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (4 or more)
//   TIMEOUT_CLKS  idle cycles that end a download
//
// Ports   :
//   clock        single clock, rising edge
//   rst          asynchronous active-low reset
//   upg_rst_i    active-high loader hold; clears the loader synchronously
//   upg_rx_i     asynchronous serial input, idles high
//   frame_err_o  sticky flag: a stop bit was sampled low
//   upg_bus      write bus toward program memory (master modport)
// ---------------------------------------------------------------------------
module uart_prog_loader #(
   parameter int unsigned CLKS_PER_BIT = 100,
   parameter int unsigned TIMEOUT_CLKS = 1000000
) (
   input  logic               clock,
   input  logic               rst,
   input  logic               upg_rx_i,
   input  logic               upg_rst_i,
   output logic               frame_err_o,
   uart_prog_loader_if.master upg_bus
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CLKS);
   localparam logic [14:0]      ADR_LAST  = 15'h7FFF;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   rx_state_t state;
   rx_state_t state_next;

   logic             rx_meta;
   logic             rx_sync;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_q;
   logic [1:0]       byte_cnt;
   logic             got_byte;
   logic [TMO_W-1:0] tmo_cnt;
   logic [14:0]      adr_q;
   logic [31:0]      dat_q;
   logic             wen_q;
   logic             done_q;
   logic             err_q;

   logic             clk_cnt_clr;
   logic             start_seen;
   logic             bit_sample;
   logic             stop_sample;

   // Receiver state register. The hold input and a finished download both
   // force IDLE through state_next, so only the async reset lives here.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and sampling strobes. START waits half a bit so that every
   // later sample lands mid-bit; a high line at that point was a glitch.
   // The bit timer is held at zero while idle so each frame starts cleanly.
   always_comb begin
      state_next  = state;
      clk_cnt_clr = 1'b0;
      start_seen  = 1'b0;
      bit_sample  = 1'b0;
      stop_sample = 1'b0;
      case (state)
         IDLE: begin
            clk_cnt_clr = 1'b1;
            if (!rx_sync) begin
               state_next = START;
               start_seen = 1'b1;
            end
         end
         START: begin
            if (clk_cnt == HALF_LAST) begin
               clk_cnt_clr = 1'b1;
               state_next  = rx_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_clr = 1'b1;
               bit_sample  = 1'b1;
               if (bit_cnt == 3'd7) begin
                  state_next = STOP;
               end
            end
         end
         STOP: begin
            if (clk_cnt == BIT_LAST) begin
               clk_cnt_clr = 1'b1;
               stop_sample = 1'b1;
               state_next  = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (upg_rst_i || done_q) begin
         state_next  = IDLE;
         start_seen  = 1'b0;
         bit_sample  = 1'b0;
         stop_sample = 1'b0;
      end
   end

   // Datapath: synchronizer, bit timer, shift register, word assembly,
   // address/strobe generation and the idle timeout. The hold input clears
   // the same state as the async reset, one edge after it is seen high.
   // The write strobe is registered so it appears the cycle after the stop
   // sample, and the address advances on the edge that ends the strobe.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         clk_cnt  <= '0;
         bit_cnt  <= '0;
         shift_q  <= '0;
         byte_cnt <= '0;
         got_byte <= 1'b0;
         tmo_cnt  <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         wen_q    <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (upg_rst_i) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         clk_cnt  <= '0;
         bit_cnt  <= '0;
         shift_q  <= '0;
         byte_cnt <= '0;
         got_byte <= 1'b0;
         tmo_cnt  <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         wen_q    <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rx_meta <= upg_rx_i;
         rx_sync <= rx_meta;
         wen_q   <= 1'b0;

         if (clk_cnt_clr) begin
            clk_cnt <= '0;
         end else begin
            clk_cnt <= clk_cnt + 1'b1;
         end

         if (start_seen) begin
            bit_cnt <= '0;
         end else if (bit_sample) begin
            shift_q <= {rx_sync, shift_q[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end

         if (stop_sample) begin
            if (rx_sync) begin
               dat_q[{byte_cnt, 3'b000} +: 8] <= shift_q;
               byte_cnt <= byte_cnt + 1'b1;
               got_byte <= 1'b1;
               wen_q    <= (byte_cnt == 2'd3);
            end else begin
               err_q <= 1'b1;
            end
         end

         // The last address ends the download instead of wrapping to 0.
         if (wen_q) begin
            if (adr_q == ADR_LAST) begin
               done_q <= 1'b1;
            end else begin
               adr_q <= adr_q + 1'b1;
            end
         end

         // Idle timeout only runs once something has been received; a
         // partial word left at timeout is dropped without a strobe.
         if (start_seen) begin
            tmo_cnt <= '0;
         end else if ((state == IDLE) && got_byte && !done_q) begin
            if (tmo_cnt == TMO_LIMIT) begin
               done_q   <= 1'b1;
               byte_cnt <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end
      end
   end

   assign upg_bus.upg_adr_o  = adr_q;
   assign upg_bus.upg_dat_o  = dat_q;
   assign upg_bus.upg_wen_o  = wen_q;
   assign upg_bus.upg_done_o = done_q;
   assign frame_err_o        = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Purpose : self-checking bench for uart_prog_loader with CLKS_PER_BIT=4 and
//           TIMEOUT_CLKS=64. Bytes are sent as real 8N1 frames; a byte-level
//           model predicts the words, addresses, done and frame-error flags,
//           and a monitor compares every write strobe against the model.
// ---------------------------------------------------------------------------
module tb_uart_prog_loader;

   localparam int CPB = 4;
   localparam int TMO = 64;

   logic clock     = 1'b0;
   logic rst       = 1'b0;
   logic upg_rst_i = 1'b0;
   logic upg_rx_i  = 1'b1;
   logic frame_err_o;

   uart_prog_loader_if upg_bus ();

   uart_prog_loader #(
      .CLKS_PER_BIT (CPB),
      .TIMEOUT_CLKS (TMO)
   ) dut (
      .clock       (clock),
      .rst         (rst),
      .upg_rx_i    (upg_rx_i),
      .upg_rst_i   (upg_rst_i),
      .frame_err_o (frame_err_o),
      .upg_bus     (upg_bus)
   );

   always #5 clock = ~clock;

   int compared   = 0;
   int mismatched = 0;

   // Model of the download: expected writes as {address, word}.
   logic [46:0] expQ[$];
   int          strobesSeen     = 0;
   int          strobesExpected = 0;
   logic [14:0] mAdr  = '0;
   logic [31:0] mWord = '0;
   int          mBytes = 0;
   bit          mDone  = 1'b0;
   bit          mErr   = 1'b0;
   bit          mAny   = 1'b0;

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      expQ.delete();
      strobesSeen     = 0;
      strobesExpected = 0;
      mAdr   = '0;
      mWord  = '0;
      mBytes = 0;
      mDone  = 1'b0;
      mErr   = 1'b0;
      mAny   = 1'b0;
   endtask

   task automatic modelByte(input logic [7:0] data, input bit stopOk);
      if (mDone) return;
      if (!stopOk) begin
         mErr = 1'b1;
         return;
      end
      mAny = 1'b1;
      mWord[mBytes*8 +: 8] = data;
      mBytes++;
      if (mBytes == 4) begin
         expQ.push_back({mAdr, mWord});
         strobesExpected++;
         mBytes = 0;
         if (mAdr == 15'h7FFF) mDone = 1'b1;
         else mAdr = mAdr + 15'd1;
      end
   endtask

   // A long idle after any accepted byte ends the download.
   task automatic modelLongIdle();
      if (mAny && !mDone) begin
         mDone  = 1'b1;
         mBytes = 0;
      end
   endtask

   // Every strobe must match the oldest predicted write.
   always @(negedge clock) begin
      logic [46:0] e;
      if (rst && upg_bus.upg_wen_o) begin
         strobesSeen++;
         if (expQ.size() == 0) begin
            checkOutput("spurious_wen", 64'(upg_bus.upg_wen_o), 64'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("wen_adr", 64'(upg_bus.upg_adr_o), 64'(e[46:32]));
            checkOutput("wen_dat", 64'(upg_bus.upg_dat_o), 64'(e[31:0]));
         end
      end
   end

   task automatic idle(input int n);
      upg_rx_i = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   // One 8N1 frame; the model is updated first so the monitor already
   // holds the prediction when the strobe appears.
   task automatic applyStimulus(input logic [7:0] data, input bit stopOk);
      logic [9:0] frame;
      modelByte(data, stopOk);
      frame = {stopOk, data, 1'b0};
      for (int i = 0; i < 10; i++) begin
         upg_rx_i = frame[i];
         repeat (CPB) @(negedge clock);
      end
      upg_rx_i = 1'b1;
      repeat (stopOk ? CPB : 3 * CPB) @(negedge clock);
      repeat ($urandom_range(3, 0)) @(negedge clock);
   endtask

   task automatic sendWord(input logic [31:0] w);
      for (int b = 0; b < 4; b++) begin
         applyStimulus(w[b*8 +: 8], 1'b1);
      end
   endtask

   task automatic doReset(input bit useHold);
      upg_rx_i = 1'b1;
      if (useHold) begin
         upg_rst_i = 1'b1;
         repeat (2) @(negedge clock);
         upg_rst_i = 1'b0;
      end else begin
         rst = 1'b0;
         repeat (2) @(negedge clock);
         rst = 1'b1;
      end
      repeat (2) @(negedge clock);
      modelReset();
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, "_adr"},     64'(upg_bus.upg_adr_o),  64'(mAdr));
      checkOutput({tag, "_dat"},     64'(upg_bus.upg_dat_o),  64'(mWord));
      checkOutput({tag, "_wen"},     64'(upg_bus.upg_wen_o),  64'd0);
      checkOutput({tag, "_done"},    64'(upg_bus.upg_done_o), 64'(mDone));
      checkOutput({tag, "_ferr"},    64'(frame_err_o),        64'(mErr));
      checkOutput({tag, "_strobes"}, 64'(strobesSeen),        64'(strobesExpected));
   endtask

   initial begin
      logic [31:0] w;
      logic [7:0]  b;
      bit          ok;

      // Power-on reset values.
      repeat (3) @(negedge clock);
      rst = 1'b1;
      repeat (2) @(negedge clock);
      modelReset();
      checkState("reset");

      // One word at address 0.
      sendWord(32'h1234_5678);
      idle(8);
      checkState("word1");

      // Two words, then a long idle ends the download.
      doReset(1'b0);
      sendWord($urandom);
      sendWord($urandom);
      idle(8);
      checkState("two_words");
      idle(30);
      checkState("before_timeout");
      idle(100);
      modelLongIdle();
      checkState("timeout");
      sendWord($urandom);
      idle(8);
      checkState("after_done");

      // Bad stop bit, then a valid word.
      doReset(1'b1);
      applyStimulus(8'hAA, 1'b0);
      idle(4);
      checkState("frame_err");
      sendWord(32'h4433_2211);
      idle(8);
      checkState("after_ferr");

      // A one-cycle glitch is not a byte and does not arm the timeout.
      doReset(1'b0);
      upg_rx_i = 1'b0;
      @(negedge clock);
      upg_rx_i = 1'b1;
      idle(100);
      checkState("glitch");
      sendWord($urandom);
      idle(8);
      checkState("after_glitch");

      // Loader hold in the middle of a byte and a word.
      doReset(1'b0);
      applyStimulus(8'hAA, 1'b0);
      applyStimulus($urandom_range(255, 1), 1'b1);
      applyStimulus($urandom_range(255, 1), 1'b1);
      upg_rx_i = 1'b0;
      repeat (3 * CPB) @(negedge clock);
      upg_rst_i = 1'b1;
      upg_rx_i  = 1'b1;
      @(negedge clock);
      modelReset();
      checkState("hold");
      repeat (2) @(negedge clock);
      upg_rst_i = 1'b0;
      repeat (2) @(negedge clock);
      sendWord($urandom);
      idle(8);
      checkState("after_hold");

      // Random byte stream with occasional framing errors.
      doReset(1'b0);
      for (int i = 0; i < 16; i++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(4, 0) != 0);
         applyStimulus(b, ok);
      end
      idle(8);
      checkState("random");

      // Last address: the strobe at 0x7FFF ends the download.
      doReset(1'b0);
      force dut.adr_q = 15'h7FFE;
      @(negedge clock);
      release dut.adr_q;
      mAdr = 15'h7FFE;
      @(negedge clock);
      sendWord($urandom);
      w = $urandom;
      sendWord(w);
      idle(8);
      checkState("last_adr");
      sendWord($urandom);
      idle(8);
      checkState("after_last");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 100: clock cycles per UART bit; legal values are 4 or more.
REQ-002 Parameter TIMEOUT_CLKS, default 1000000: idle cycles that end a download.
REQ-003 clock  input  1: single clock; all state changes on its rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 upg_rst_i  input  1: active-high loader hold; while high the loader is idle and ignores rx.
REQ-006 upg_rx_i  input  1: asynchronous serial line; idles high; 8N1 format, LSB first.
REQ-007 upg_adr_o  output  15: word address; bit 14 is the memory select consumed downstream.
REQ-008 upg_dat_o  output  32: assembled word.
REQ-009 upg_wen_o  output  1: one-cycle write strobe for upg_adr_o/upg_dat_o.
REQ-010 upg_done_o  output  1: download complete (sticky).
REQ-011 frame_err_o  output  1: sticky flag; a stop bit was sampled low.

Function
REQ-012 upg_rx_i SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-013 Receiver FSM states: IDLE, START, DATA, STOP.
REQ-014 IDLE->START: synchronized rx is low.
REQ-015 START: wait CLKS_PER_BIT/2 cycles, then resample; rx high -> back to IDLE (glitch, no byte); rx low -> DATA.
REQ-016 DATA: sample 8 bits, each CLKS_PER_BIT cycles apart, mid-bit, LSB first into a shift register; then go to STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles. High -> byte accepted. Low -> byte discarded and frame_err_o set. Both cases return to IDLE.
REQ-018 Accepted bytes SHALL fill upg_dat_o little-endian: byte counter 0..3 selects bits [8k+7:8k]; the counter wraps 3->0.
REQ-019 On the 4th accepted byte, upg_wen_o SHALL pulse high for exactly one cycle, the cycle after the stop-bit sample. upg_dat_o holds the complete word and upg_adr_o the current address during that cycle.
REQ-020 upg_adr_o SHALL increment by 1 on the cycle after each upg_wen_o pulse. upg_dat_o SHALL stay stable until the next byte is written into it.
REQ-021 Timeout counter: counts cycles while FSM is IDLE and at least one byte has been accepted since the last reset/hold. It clears on every IDLE->START transition.
REQ-022 When the timeout counter reaches TIMEOUT_CLKS, upg_done_o SHALL go high on the next cycle. Any partial word (byte counter != 0) is discarded with no strobe.
REQ-023 A strobe at address 0x7FFF SHALL set upg_done_o on the following cycle. The address does not wrap.
REQ-024 Once upg_done_o is high: rx is ignored, no further strobes occur, and all outputs hold until rst or upg_rst_i.
REQ-025 No timeout and no done while zero bytes have been accepted; the loader waits indefinitely.
REQ-026 If upg_rst_i rises mid-byte or mid-word, then on the next cycle: FSM goes to IDLE, counters clear, upg_wen_o is 0, and no partial strobe is emitted.

Reset
REQ-027 rst low, or upg_rst_i high, SHALL give: FSM IDLE, synchronizer 1, upg_adr_o 0, upg_dat_o 0, upg_wen_o 0, upg_done_o 0, byte/bit/timeout counters 0.
REQ-028 frame_err_o is cleared by rst and by upg_rst_i.
REQ-029 rst SHALL act asynchronously on assertion. Release is sampled synchronously; the first rx sample is taken on the second edge after release.

Verification (CLKS_PER_BIT=4, TIMEOUT_CLKS=64)
REQ-030 Send bytes 0x78,0x56,0x34,0x12 -> exactly one upg_wen_o pulse with upg_adr_o=0x0000 and upg_dat_o=0x12345678; afterwards upg_adr_o=0x0001.
REQ-031 Send two words, then stay idle for 64 cycles -> strobes at addresses 0 and 1, then upg_done_o=1; later bytes produce no strobe.
REQ-032 Send 0xAA with stop bit forced low, then a valid word 0x11,0x22,0x33,0x44 -> frame_err_o=1; one strobe with data 0x44332211 at address 0.
REQ-033 Send a 1-cycle low glitch on rx in IDLE -> no byte accepted, byte counter unchanged, no strobe.
REQ-034 Preload address to 0x7FFE via 2 prior words after forcing, or run the full sequence -> the strobe at 0x7FFF is followed by upg_done_o=1 and no strobe at address 0.
REQ-035 Send 2 bytes, then assert upg_rst_i -> all outputs return to reset values; a subsequent full word writes address 0 with only the new bytes.
